// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory port arbiter.
package imem_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_B0   = 3'd1,
        ST_B1   = 3'd2,
        ST_B2   = 3'd3,
        ST_B3   = 3'd4
    } arb_state_e;

    localparam int BYTES_PER_WORD     = 4;
    localparam int STARVE_MAX_DEFAULT = 8;

    // Big-endian byte lane: index 0 is the most significant byte.
    function automatic logic [7:0] word_byte(input logic [31:0] word, input int idx);
        return word[8*(BYTES_PER_WORD-1-idx) +: 8];
    endfunction

endpackage

// File: rtl/imem_starve_ctr.sv
// Saturating starvation counter: counts lost loader arbitrations, raises force_grant at the limit.
module imem_starve_ctr
    import imem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic force_grant
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] count_r;

    // Count consecutive lost cycles, holding at the limit until cleared.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (inc && (count_r != CW'(STARVE_MAX))) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign force_grant = (count_r == CW'(STARVE_MAX));

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares a byte-wide instruction memory between fetch reads and a word loader.
// Optional loader anti-starvation is enabled by defining IMEM_ARB_STARVE_EN.
module imem_port_arbiter
    import imem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [31:0]       fetch_data,
    output logic              fetch_valid,
    output logic              fetch_stall,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [7:0]        mem_wdata
);

    arb_state_e        state_r;
    logic [ADDR_W-1:0] word_addr_r;
    logic [31:0]       word_data_r;
    logic              we_r;
    logic [ADDR_W-1:0] waddr_r;
    logic [7:0]        wdata_r;
    logic              force_s;

`ifdef IMEM_ARB_STARVE_EN
    logic starve_inc_s;
    logic starve_clr_s;
    logic starve_force_s;

    assign starve_inc_s = rst_n && (state_r == ST_IDLE) && ld_valid && fetch_req && !force_s;
    assign starve_clr_s = !ld_valid || ld_ready;

    imem_starve_ctr #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc        (starve_inc_s),
        .clr        (starve_clr_s),
        .force_grant(starve_force_s)
    );

    assign force_s = starve_force_s & ld_valid;
`else
    // Strict fetch priority; STARVE_MAX has no effect in this build.
    assign force_s = 1'b0 & (STARVE_MAX == 0);
`endif

    assign mem_addr   = fetch_addr;
    assign fetch_data = mem_rdata;

    // Writes are suppressed immediately while reset is held so an aborted word stops cleanly.
    assign mem_we    = we_r & rst_n;
    assign mem_waddr = rst_n ? waddr_r : '0;
    assign mem_wdata = rst_n ? wdata_r : 8'h00;

    // Fetch/loader grant and stall decode from the current state.
    always_comb begin
        fetch_valid = 1'b0;
        fetch_stall = 1'b0;
        ld_ready    = 1'b0;
        if (!rst_n) begin
            fetch_valid = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    fetch_valid = fetch_req & ~force_s;
                    fetch_stall = force_s;
                    ld_ready    = ld_valid & (~fetch_req | force_s);
                end
                ST_B0, ST_B1, ST_B2, ST_B3: fetch_stall = 1'b1;
                default: fetch_stall = 1'b1;
            endcase
        end
    end

    // Write sequencer: latch the word on accept, then emit four bytes MSB first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            word_addr_r <= '0;
            word_data_r <= 32'h0000_0000;
            we_r        <= 1'b0;
            waddr_r     <= '0;
            wdata_r     <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ld_ready) begin
                        state_r     <= ST_B0;
                        word_addr_r <= ld_addr;
                        word_data_r <= ld_data;
                        we_r        <= 1'b1;
                        waddr_r     <= ld_addr;
                        wdata_r     <= word_byte(ld_data, 0);
                    end else begin
                        we_r <= 1'b0;
                    end
                end
                ST_B0: begin
                    state_r <= ST_B1;
                    waddr_r <= word_addr_r + ADDR_W'(1);
                    wdata_r <= word_byte(word_data_r, 1);
                end
                ST_B1: begin
                    state_r <= ST_B2;
                    waddr_r <= word_addr_r + ADDR_W'(2);
                    wdata_r <= word_byte(word_data_r, 2);
                end
                ST_B2: begin
                    state_r <= ST_B3;
                    waddr_r <= word_addr_r + ADDR_W'(3);
                    wdata_r <= word_byte(word_data_r, 3);
                end
                ST_B3: begin
                    state_r <= ST_IDLE;
                    we_r    <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    we_r    <= 1'b0;
                end
            endcase
        end
    end

endmodule
